// File: rtl/pipe_ctrl_pkg.sv
// Shared scoreboard types, forwarding-select codes and the register-match helper
// for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int SB_RA_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic               valid;
      logic               regwrite;
      logic               memread;
      logic [SB_RA_W-1:0] wreg;
      logic [SB_RA_W-1:0] rs;
      logic [SB_RA_W-1:0] rt;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '0;

   // $0 is hard-wired, so a write to it can never create a dependency.
   function automatic logic sb_writes(input sb_entry_t w, input logic [SB_RA_W-1:0] r);
      return w.valid && w.regwrite && (w.wreg != '0) && (w.wreg == r);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage request / hazard-control response bundle between the pipeline
// datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
);
   logic            id_valid;
   logic [RA_W-1:0] id_rs;
   logic [RA_W-1:0] id_rt;
   logic            id_use_rs;
   logic            id_use_rt;
   logic [RA_W-1:0] id_wreg;
   logic            id_regwrite;
   logic            id_memread;
   logic            ex_redirect;

   logic             stall;
   logic             flush_ifid;
   logic             bubble_ex;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_wreg, id_regwrite, id_memread, ex_redirect,
      input  stall, flush_ifid, bubble_ex, fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_wreg, id_regwrite, id_memread, ex_redirect,
      output stall, flush_ifid, bubble_ex, fwd_a, fwd_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_sb_stage.sv
// One scoreboard register shadowing an in-flight instruction; loads an
// all-invalid entry on reset or when a bubble is injected.
module hazard_sb_stage
   import pipe_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      bubble,
   input  sb_entry_t d,
   output sb_entry_t q
);

   always_ff @(posedge clk) begin
      if (reset || bubble) q <= SB_BUBBLE;
      else                 q <= d;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage MIPS hazard controller: EX/MEM/WB scoreboard, stall/flush/bubble,
// ALU forwarding selects and saturating counters. Option macro: PIPE_FORWARDING_EN.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input logic                clk,
   input logic                reset,
   pipeline_hazard_ctrl_if.slave bus
);

   if (RA_W != SB_RA_W) begin : g_ra_w_check
      $error("RA_W must equal pipe_ctrl_pkg::SB_RA_W");
   end

   sb_entry_t        id_e, ex_q, mem_q, wb_q;
   logic             rs_hit, rt_hit, hazard, stall_c, bubble_c;
   logic [1:0]       fwd_a_c, fwd_b_c;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             unused_sb;

   always_comb begin
      id_e          = SB_BUBBLE;
      id_e.valid    = bus.id_valid;
      id_e.regwrite = bus.id_regwrite;
      id_e.memread  = bus.id_memread;
      id_e.wreg     = bus.id_wreg;
      id_e.rs       = bus.id_rs;
      id_e.rt       = bus.id_rt;
   end

   hazard_sb_stage u_sb_ex  (.clk(clk), .reset(reset), .bubble(bubble_c), .d(id_e),  .q(ex_q));
   hazard_sb_stage u_sb_mem (.clk(clk), .reset(reset), .bubble(1'b0),     .d(ex_q),  .q(mem_q));
   hazard_sb_stage u_sb_wb  (.clk(clk), .reset(reset), .bubble(1'b0),     .d(mem_q), .q(wb_q));

   // Not every scoreboard field feeds logic in every build.
   assign unused_sb = ^{ex_q, mem_q, wb_q};

   always_comb begin
`ifdef PIPE_FORWARDING_EN
      // Only a load in EX cannot be forwarded in time; MEM beats WB as the younger writer.
      rs_hit  = ex_q.memread && sb_writes(ex_q, bus.id_rs);
      rt_hit  = ex_q.memread && sb_writes(ex_q, bus.id_rt);
      fwd_a_c = sb_writes(mem_q, ex_q.rs) ? FWD_MEM :
                sb_writes(wb_q,  ex_q.rs) ? FWD_WB  : FWD_RF;
      fwd_b_c = sb_writes(mem_q, ex_q.rt) ? FWD_MEM :
                sb_writes(wb_q,  ex_q.rt) ? FWD_WB  : FWD_RF;
`else
      // Write-before-read RF covers WB; anything in EX or MEM must drain first.
      rs_hit  = sb_writes(ex_q, bus.id_rs) || sb_writes(mem_q, bus.id_rs);
      rt_hit  = sb_writes(ex_q, bus.id_rt) || sb_writes(mem_q, bus.id_rt);
      fwd_a_c = FWD_RF;
      fwd_b_c = FWD_RF;
`endif
      hazard   = bus.id_valid && ((bus.id_use_rs && rs_hit) || (bus.id_use_rt && rt_hit));
      stall_c  = hazard && !bus.ex_redirect;
      bubble_c = stall_c || bus.ex_redirect;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_c && (stall_cnt_q != '1))         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (bus.ex_redirect && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   // Reset masks every output immediately, including counters mid-update.
   always_comb begin
      bus.stall      = 1'b0;
      bus.flush_ifid = 1'b0;
      bus.bubble_ex  = 1'b0;
      bus.fwd_a      = FWD_RF;
      bus.fwd_b      = FWD_RF;
      bus.stall_cnt  = '0;
      bus.flush_cnt  = '0;
      if (!reset) begin
         bus.stall      = stall_c;
         bus.flush_ifid = bus.ex_redirect;
         bus.bubble_ex  = bubble_c;
         bus.fwd_a      = fwd_a_c;
         bus.fwd_b      = fwd_b_c;
         bus.stall_cnt  = stall_cnt_q;
         bus.flush_cnt  = flush_cnt_q;
      end
   end

endmodule
